// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable clock divider and tick generator
//
// Purpose:
//   Width-parametrised down-counter that divides clkin by a loadable terminal
//   value N. Two output modes: toggle (50% square wave, period 2*(N+1)) and
//   pulse (clkout mirrors the one-cycle tick, period N+1). New divisor/mode
//   values are captured into a pending slot and only take effect on a period
//   boundary (or immediately while disabled), so clkout never glitches.
//
// Optional feature (macro CLKDIV_SYNC_EN):
//   Adds input sync_in. A rising edge on sync_in restarts the period
//   (cnt reload, clkout = 0, tick = 0), taking priority over a terminal event.
//   This is used to phase-align several dividers.
//
// Ports:
//   clkin      in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   count enable
//   div_in     in   [CNT_W-1:0] new terminal value N
//   mode_in    in   new mode: 0 toggle, 1 pulse
//   div_load   in   single-cycle request capturing div_in/mode_in
//   sync_in    in   phase-align request (CLKDIV_SYNC_EN only)
//   div_ack    out  one-cycle pulse when the captured values become active
//   load_pend  out  high while a captured load awaits application
//   clkout     out  divided clock (toggle) or tick copy (pulse)
//   tick       out  one-cycle pulse at each terminal count

module clk_div_prog #(
   parameter int          CNT_W      = 15,
   parameter int unsigned DIV_RESET  = 24999,
   parameter logic        MODE_RESET = 1'b0
) (
   input  logic             clkin,
   input  logic             rst_n,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             mode_in,
   input  logic             div_load,
`ifdef CLKDIV_SYNC_EN
   input  logic             sync_in,
`endif
   output logic             div_ack,
   output logic             load_pend,
   output logic             clkout,
   output logic             tick
);

   localparam logic [CNT_W-1:0] DIV_INIT = DIV_RESET[CNT_W-1:0];
   localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] act_div;
   logic             act_mode;
   logic [CNT_W-1:0] pend_div;
   logic             pend_mode;

   logic [CNT_W-1:0] cnt_nxt;
   logic             clkout_nxt;
   logic             tick_nxt;
   logic             take_pend;
   logic             terminal;
   logic             sync_hit;

   assign terminal = (cnt == '0);

`ifdef CLKDIV_SYNC_EN
   // Two-stage copy of sync_in; a rising edge is seen as q1 high, q2 low,
   // and the period restart happens on the edge after that detection.
   logic sync_q1;
   logic sync_q2;

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= sync_in;
         sync_q2 <= sync_q1;
      end
   end

   assign sync_hit = sync_q1 & ~sync_q2;
`else
   assign sync_hit = 1'b0;
`endif

   // Next-state selection. Priority: sync restart, disabled, terminal, count.
   // take_pend marks the edge on which the pending load becomes active; the
   // pending values used are those held before the edge, so a div_load that
   // arrives on the same edge is kept for the following boundary.
   always_comb begin
      cnt_nxt    = cnt;
      clkout_nxt = clkout;
      tick_nxt   = 1'b0;
      take_pend  = 1'b0;

      if (sync_hit) begin
         take_pend  = load_pend;
         cnt_nxt    = load_pend ? pend_div : act_div;
         clkout_nxt = 1'b0;
      end else if (!en) begin
         // While stopped a pending load is applied straight away; a switch
         // to pulse mode must not leave clkout parked high.
         if (load_pend) begin
            take_pend = 1'b1;
            cnt_nxt   = pend_div;
            if (pend_mode) begin
               clkout_nxt = 1'b0;
            end
         end
      end else if (terminal) begin
         tick_nxt = 1'b1;
         if (load_pend) begin
            take_pend = 1'b1;
            cnt_nxt   = pend_div;
            if (pend_mode) begin
               clkout_nxt = 1'b1;          // pulse rule from this edge
            end else if (act_mode) begin
               clkout_nxt = 1'b0;          // pulse->toggle starts low
            end else begin
               clkout_nxt = ~clkout;
            end
         end else begin
            cnt_nxt    = act_div;
            clkout_nxt = act_mode ? 1'b1 : ~clkout;
         end
      end else begin
         // Reload at zero happens above, so this never wraps.
         cnt_nxt = cnt - ONE;
         if (act_mode) begin
            clkout_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= DIV_INIT;
         act_div   <= DIV_INIT;
         act_mode  <= MODE_RESET;
         pend_div  <= '0;
         pend_mode <= 1'b0;
         load_pend <= 1'b0;
         clkout    <= 1'b0;
         tick      <= 1'b0;
         div_ack   <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         clkout  <= clkout_nxt;
         tick    <= tick_nxt;
         div_ack <= take_pend;

         if (take_pend) begin
            act_div  <= pend_div;
            act_mode <= pend_mode;
         end

         // Last write wins; a fresh capture keeps load_pend set even when
         // the previous pending values are being applied on this edge.
         if (div_load) begin
            pend_div  <= div_in;
            pend_mode <= mode_in;
            load_pend <= 1'b1;
         end else if (take_pend) begin
            load_pend <= 1'b0;
         end
      end
   end

endmodule
